// File: rtl/display_pkg.sv
// Shared types and width helpers for the multiplexed 7-segment scan controller.
package display_pkg;

   typedef enum logic [1:0] {
      APAGADO,
      BLANQUEO,
      ENCENDIDO
   } estado_t;

   localparam int unsigned N_DIGITOS_DEF    = 4;
   localparam int unsigned DIV_REFRESCO_DEF = 100000;

   // A zero-width vector is illegal, so widths never drop below one bit.
   function automatic int unsigned ancho_min1(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned CNT_W = $clog2(DIV_REFRESCO_DEF);
   localparam int unsigned IDX_W = ancho_min1(N_DIGITOS_DEF);

endpackage

// File: rtl/divisor_refresco.sv
// Per-digit slot counter: counts 0..DIV_REFRESCO-1 and flags the end of blanking and of the slot.
module divisor_refresco #(
   parameter int unsigned DIV_REFRESCO = 100000,
   parameter int unsigned T_BLANCO     = 1000,
   parameter int unsigned CNT_W        = 17
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             limpiar_i,
   output logic [CNT_W-1:0] cnt_d_o,
   output logic             fin_slot_o,
   output logic             fin_blanco_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign fin_slot_o   = (cnt_q == CNT_W'(DIV_REFRESCO - 1));
   assign fin_blanco_o = (cnt_q == CNT_W'(T_BLANCO - 1));
   assign cnt_d_o      = cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (limpiar_i || fin_slot_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/control_display.sv
// Scan controller: double-buffered BCD value, per-slot blanking, leading-zero suppression,
// active-low anode drive. All outputs are registered from next-state values.
module control_display
   import display_pkg::*;
#(
   parameter int unsigned N_DIGITOS    = 4,
   parameter int unsigned DIV_REFRESCO = 100000,
   parameter int unsigned T_BLANCO     = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   habilitar,
   input  logic                   carga,
   input  logic [4*N_DIGITOS-1:0] valor,
   input  logic [N_DIGITOS-1:0]   punto,
   input  logic                   supr_ceros,
   output logic [3:0]             digito_bcd,
   output logic [N_DIGITOS-1:0]   anodos,
   output logic                   punto_n,
   output logic                   fin_trama
);

   localparam int unsigned     CntW   = ancho_min1(DIV_REFRESCO);
   localparam int unsigned     IdxW   = ancho_min1(N_DIGITOS);
   localparam logic [IdxW-1:0] IdxUlt = IdxW'(N_DIGITOS - 1);
   localparam logic [CntW-1:0] CntUlt = CntW'(DIV_REFRESCO - 1);

   estado_t                state_q, state_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [CntW-1:0]        cnt_d;
   logic                   fin_slot, fin_blanco, limpiar, inicio_trama;

   logic [4*N_DIGITOS-1:0] pend_valor_q, pend_valor_d, sh_valor_q, sh_valor_d;
   logic [N_DIGITOS-1:0]   pend_punto_q, pend_punto_d, sh_punto_q, sh_punto_d;

   logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
   logic [3:0]             digito_q, digito_d;
   logic                   punto_n_q, punto_n_d;
   logic                   fin_trama_q, fin_trama_d;

   logic [3:0]             nibble;
   logic                   ceros_arriba, apagar;

   divisor_refresco #(
      .DIV_REFRESCO(DIV_REFRESCO),
      .T_BLANCO    (T_BLANCO),
      .CNT_W       (CntW)
   ) u_divisor (
      .clk_i       (clk),
      .rst_i       (rst),
      .limpiar_i   (limpiar),
      .cnt_d_o     (cnt_d),
      .fin_slot_o  (fin_slot),
      .fin_blanco_o(fin_blanco)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      limpiar      = 1'b0;
      inicio_trama = 1'b0;
      if (!habilitar) begin
         state_d = APAGADO;
         idx_d   = '0;
         limpiar = 1'b1;
      end else begin
         unique case (state_q)
            APAGADO: begin
               state_d      = BLANQUEO;
               idx_d        = '0;
               limpiar      = 1'b1;
               inicio_trama = 1'b1;
            end
            BLANQUEO: begin
               if (fin_blanco) state_d = ENCENDIDO;
            end
            ENCENDIDO: begin
               if (fin_slot) begin
                  state_d = BLANQUEO;
                  if (idx_q == IdxUlt) begin
                     idx_d        = '0;
                     inicio_trama = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = APAGADO;
               idx_d   = '0;
               limpiar = 1'b1;
            end
         endcase
      end
   end

   // A strobe on the frame-start edge goes straight to the shadow so it is not a frame late.
   always_comb begin
      pend_valor_d = carga ? valor : pend_valor_q;
      pend_punto_d = carga ? punto : pend_punto_q;
      sh_valor_d   = sh_valor_q;
      sh_punto_d   = sh_punto_q;
      if (inicio_trama) begin
         sh_valor_d = carga ? valor : pend_valor_q;
         sh_punto_d = carga ? punto : pend_punto_q;
      end
   end

   always_comb begin
      nibble       = sh_valor_d[4*int'(idx_d) +: 4];
      ceros_arriba = 1'b1;
      for (int i = 0; i < int'(N_DIGITOS); i++) begin
         if (i >= int'(idx_d) && sh_valor_d[4*i +: 4] != 4'd0) ceros_arriba = 1'b0;
      end
      apagar = (nibble > 4'd9) || (supr_ceros && ceros_arriba && (idx_d != '0));

      anodos_d  = '1;
      digito_d  = '0;
      punto_n_d = 1'b1;
      if (state_d == ENCENDIDO && !apagar) begin
         anodos_d[idx_d] = 1'b0;
         digito_d        = nibble;
         punto_n_d       = ~sh_punto_d[idx_d];
      end
      fin_trama_d = (state_d == ENCENDIDO) && (idx_d == IdxUlt) && (cnt_d == CntUlt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= APAGADO;
         idx_q        <= '0;
         pend_valor_q <= '0;
         pend_punto_q <= '0;
         sh_valor_q   <= '0;
         sh_punto_q   <= '0;
         anodos_q     <= '1;
         digito_q     <= '0;
         punto_n_q    <= 1'b1;
         fin_trama_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pend_valor_q <= pend_valor_d;
         pend_punto_q <= pend_punto_d;
         sh_valor_q   <= sh_valor_d;
         sh_punto_q   <= sh_punto_d;
         anodos_q     <= anodos_d;
         digito_q     <= digito_d;
         punto_n_q    <= punto_n_d;
         fin_trama_q  <= fin_trama_d;
      end
   end

   assign anodos     = anodos_q;
   assign digito_bcd = digito_q;
   assign punto_n    = punto_n_q;
   assign fin_trama  = fin_trama_q;

endmodule

// File: tb/tb_control_display.sv
// Bench for control_display: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_control_display;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int TB    = 2;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        rst, habilitar, carga, supr_ceros;
   logic [15:0] valor;
   logic [3:0]  punto;
   logic [3:0]  digito_bcd;
   logic [3:0]  anodos;
   logic        punto_n, fin_trama;

   int errors = 0;
   int checks = 0;

   // Reference model: whether scanning, position inside the frame, and the two buffers.
   bit          m_act = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_pend_v = '0, m_sh_v = '0;
   logic [3:0]  m_pend_p = '0, m_sh_p = '0;
   logic [3:0]  e_an = 4'hF, e_dig = 4'h0;
   logic        e_pn = 1'b1, e_fin = 1'b0;

   control_display #(
      .N_DIGITOS   (N),
      .DIV_REFRESCO(DIV),
      .T_BLANCO    (TB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .habilitar (habilitar),
      .carga     (carga),
      .valor     (valor),
      .punto     (punto),
      .supr_ceros(supr_ceros),
      .digito_bcd(digito_bcd),
      .anodos    (anodos),
      .punto_n   (punto_n),
      .fin_trama (fin_trama)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit          inicio;
      int          d, c;
      logic [3:0]  nib;
      bit          apagar;
      inicio = 1'b0;
      if (rst) begin
         m_act = 1'b0; m_pos = 0;
         m_pend_v = '0; m_pend_p = '0; m_sh_v = '0; m_sh_p = '0;
      end else begin
         if (!habilitar) begin
            m_act = 1'b0;
         end else if (!m_act) begin
            m_act = 1'b1; m_pos = 0; inicio = 1'b1;
         end else begin
            m_pos  = (m_pos + 1) % FRAME;
            inicio = (m_pos == 0);
         end
         if (inicio) begin
            m_sh_v = carga ? valor : m_pend_v;
            m_sh_p = carga ? punto : m_pend_p;
         end
         if (carga) begin
            m_pend_v = valor; m_pend_p = punto;
         end
      end
      e_an = 4'hF; e_dig = 4'h0; e_pn = 1'b1; e_fin = 1'b0;
      if (!rst && m_act) begin
         d = m_pos / DIV;
         c = m_pos % DIV;
         if (c >= TB) begin
            nib    = 4'((m_sh_v >> (4 * d)) & 16'hF);
            apagar = (nib > 9) || (supr_ceros && d != 0 && (m_sh_v >> (4 * d)) == 16'h0);
            if (!apagar) begin
               e_an  = ~(4'b0001 << d);
               e_dig = nib;
               e_pn  = ~m_sh_p[d];
            end
         end
         e_fin = (m_pos == FRAME - 1);
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("anodos", 32'(anodos), 32'(e_an));
      check("digito_bcd", 32'(digito_bcd), 32'(e_dig));
      check("punto_n", 32'(punto_n), 32'(e_pn));
      check("fin_trama", 32'(fin_trama), 32'(e_fin));
   endtask

   task automatic lit_digit(input string name, input logic [3:0] an, input logic [3:0] dig);
      check({name, ".anodos"}, 32'(anodos), 32'(an));
      check({name, ".digito"}, 32'(digito_bcd), 32'(dig));
   endtask

   task automatic lit_reset(input string name);
      check({name, ".anodos"}, 32'(anodos), 32'hF);
      check({name, ".digito"}, 32'(digito_bcd), 32'h0);
      check({name, ".punto_n"}, 32'(punto_n), 32'h1);
      check({name, ".fin_trama"}, 32'(fin_trama), 32'h0);
   endtask

   initial begin
      logic [3:0] r;
      rst = 1'b1; habilitar = 1'b0; carga = 1'b0; supr_ceros = 1'b0;
      valor = '0; punto = '0;

      tick(); tick();
      lit_reset("reset");
      rst = 1'b0;

      // Basic scan and no-tearing load.
      valor = 16'h1234; carga = 1'b1;
      tick();
      carga = 1'b0; habilitar = 1'b1;
      for (int c = 0; c < 64; c++) begin
         tick();
         if (c == 1)  check("scan.blank1", 32'(anodos), 32'hF);
         if (c == 2)  lit_digit("scan.d0", 4'b1110, 4'd4);
         if (c == 10) lit_digit("scan.d1", 4'b1101, 4'd3);
         if (c == 18) lit_digit("tear.d2", 4'b1011, 4'd2);
         if (c == 26) lit_digit("tear.d3", 4'b0111, 4'd1);
         if (c == 30) check("scan.fin30", 32'(fin_trama), 32'h0);
         if (c == 31) check("scan.fin31", 32'(fin_trama), 32'h1);
         if (c == 34) lit_digit("tear.next0", 4'b1110, 4'd8);
         if (c == 58) lit_digit("tear.next3", 4'b0111, 4'd5);
         if (c == 12) begin valor = 16'h5678; carga = 1'b1; end
         if (c == 13) carga = 1'b0;
      end

      // Zero suppression, invalid nibble, decimal point, disable mid-scan.
      for (int c = 0; c < 178; c++) begin
         tick();
         if (c == 34)  lit_digit("supr.d0", 4'b1110, 4'd0);
         if (c == 42)  lit_digit("supr.d1", 4'b1101, 4'd7);
         if (c == 50)  check("supr.d2", 32'(anodos), 32'hF);
         if (c == 58)  check("supr.d3", 32'(anodos), 32'hF);
         if (c == 66)  lit_digit("zero.d0", 4'b1110, 4'd0);
         if (c == 74)  check("bypass.d1", 32'(anodos), 32'hF);
         if (c == 98)  lit_digit("inval.d0", 4'b1110, 4'd4);
         if (c == 106) lit_digit("inval.d1", 4'b1111, 4'd0);
         if (c == 138) check("dp.d1", 32'(punto_n), 32'h1);
         if (c == 145) check("dp.blank", 32'(punto_n), 32'h1);
         if (c == 146) check("dp.d2", 32'(punto_n), 32'h0);
         if (c == 174) check("dis.anodos", 32'(anodos), 32'hF);
         case (c)
            0:   begin supr_ceros = 1'b1; valor = 16'h0070; carga = 1'b1; end
            1:   carga = 1'b0;
            63:  begin valor = 16'h0000; carga = 1'b1; end
            64:  carga = 1'b0;
            95:  begin supr_ceros = 1'b0; valor = 16'h12A4; carga = 1'b1; end
            96:  carga = 1'b0;
            127: begin valor = 16'h1234; punto = 4'b0100; carga = 1'b1; end
            128: carga = 1'b0;
            173: habilitar = 1'b0;
            177: habilitar = 1'b1;
            default: ;
         endcase
      end

      // Re-enable restarts at digit 0; reset mid-scan drops buffered data.
      for (int d = 0; d < 60; d++) begin
         tick();
         if (d == 1)  check("reen.blank", 32'(anodos), 32'hF);
         if (d == 2)  lit_digit("reen.d0", 4'b1110, 4'd4);
         if (d == 21) lit_reset("rst_mid");
         if (d == 24) lit_digit("post_rst.d0", 4'b1110, 4'd0);
         if (d == 32) lit_digit("post_rst.d1", 4'b1101, 4'd0);
         if (d == 20) rst = 1'b1;
         if (d == 21) rst = 1'b0;
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 999) < 3);
         if (habilitar) habilitar = ($urandom_range(0, 99) >= 2);
         else           habilitar = ($urandom_range(0, 9) < 3);
         carga = ($urandom_range(0, 99) < 6);
         for (int i = 0; i < N; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r = 4'd0;
            valor[4*i +: 4] = r;
         end
         punto = 4'($urandom);
         if ($urandom_range(0, 99) < 2) supr_ceros = ~supr_ceros;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
